count_sequence_checker: RTL and testbench
=========================================

# count_sequence_checker

Passive checker that sits on the output of the team's bounded up-counters, e.g. the count-to-three block, and verifies the counter stream they drive. It samples a 3-bit count on each valid cycle and flags any value above three. It also flags illegal steps; the only legal steps are hold, or +1 below three. It keeps sticky error flags, a saturating violation counter and the highest legal value seen, for status registers and assertions in the system.

## Interface
- `ERR_W`, default 4: width of the violation counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cnt_in`  in  3  count value driven by the counter under observation.
- `cnt_valid`  in  1  `cnt_in` is sampled only when high.
- `err_clr`  in  1  synchronous clear of `err_over`, `err_step` and `err_count`.
- `err_over`  out  1  sticky: a valid sample had `cnt_in` > 3.
- `err_step`  out  1  sticky: a valid in-range sample broke the step rule (absent when `CHECK_STEP_EN` is undefined).
- `err_count`  out  ERR_W  number of violating samples, saturating.
- `max_seen`  out  3  highest in-range value sampled since reset.
- `at_max`  out  1  high while the FSM is in AT_MAX.

## Operation
- FSM states: IDLE, TRACK and AT_MAX. The register `prev[1:0]` holds the last accepted value.
- IDLE: the first valid sample in 0..3 is accepted with no step check.
  - Writes `prev`.
  - Moves to AT_MAX if the sample is 3, otherwise to TRACK.
- TRACK:
  - Legal sample: n == prev, or n == prev+1. The sample writes `prev`.
  - Moves to AT_MAX when a sample of 3 is accepted.
- AT_MAX: the only legal sample is 3.
  - Any other in-range sample is a step violation.
  - The FSM resyncs: `prev` is set to the sample and the state goes to TRACK.
- Step violation in TRACK:
  - Sets `err_step`.
  - `prev` resyncs to the sample; the state stays TRACK, or goes to AT_MAX if the sample is 3.
- Over-range sample (4..7):
  - Sets `err_over`.
  - `prev`, the state and `max_seen` are unchanged, and no step check is made.
- Each violating sample increments `err_count` by exactly 1. `err_count` saturates at 2^ERR_W−1.
- `max_seen` takes the maximum of its current value and every accepted in-range sample. `err_clr` does not affect it.
- `cnt_valid` low: no state or output changes.

## Timing
- Reset values: state IDLE, `prev`=0, `err_over`=0, `err_step`=0, `err_count`=0, `max_seen`=0, `at_max`=0.
- All outputs are registered, with 1-cycle latency. A sample at edge N is reflected on the outputs after edge N.
- `err_clr` together with a violating sample in the same cycle: the violation wins.
  - The flag of that violation type is 1, the other flag is 0.
  - `err_count`=1.
- `err_clr` with no violation: flags and count are 0 after the edge. The FSM is unaffected.
- `reset` asserted mid-stream: all state clears immediately. The first valid sample after release is treated as an IDLE sample.

## Configuration
- `CHECK_STEP_EN` defined:
  - Full step checking as described.
  - The `err_step` port is present.
- `CHECK_STEP_EN` undefined:
  - Only the range check is made.
  - The `err_step` port is absent.
  - In-range samples never count as violations.
  - The FSM still tracks `prev`, `at_max` and `max_seen`.

## Test plan
- Stream 0,1,2,3,3,3 with `cnt_valid`=1 -> no errors; `at_max`=1 from the cycle after the first 3; `max_seen`=3.
- Stream 0,1,6,2 -> `err_over`=1, `err_count`=1, `err_step`=0 (6 is ignored, so 1->2 is legal); `max_seen`=2.
- Stream 0,2, then 3,1 -> `err_step`=1 after the 2 and `err_count`=2 after the 1; `at_max`=0 after the 1. Without `CHECK_STEP_EN`: `err_count`=0.
- 20 samples of 7 with `ERR_W`=4 -> `err_count` saturates at 15; then `err_clr` with a sample of 5 -> `err_count`=1, `err_over`=1.
- Reach AT_MAX, then pulse `reset` asynchronously between edges -> all outputs are 0 immediately; a next sample of 2 is accepted with no error.
- `cnt_valid`=0 with `cnt_in`=7 for 5 cycles -> no output change.

Source files
------------

// File: rtl/count_sequence_checker.sv
// count_sequence_checker
//
// Passive monitor for the bounded up-counters (count-to-three and friends).
// Every valid sample is range-checked (0..3 legal). When CHECK_STEP_EN is
// defined, in-range samples are also step-checked: only "hold" or "+1 below
// three" is legal, and once at 3 the counter must stay at 3. Violations set
// sticky flags and bump a saturating counter. The highest accepted in-range
// value is kept for status readback.
//
// Build option:
//   CHECK_STEP_EN  defined   -> step checking on, err_step port present
//                  undefined -> range check only, no err_step port
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   cnt_in     in   [2:0] count from the counter under observation
//   cnt_valid  in   qualifies cnt_in
//   err_clr    in   synchronous clear of flags and err_count
//   err_over   out  sticky, a valid sample was above 3
//   err_step   out  sticky, a valid in-range sample broke the step rule
//   err_count  out  [ERR_W-1:0] violating samples, saturating
//   max_seen   out  [2:0] highest accepted in-range value since reset
//   at_max     out  FSM is in AT_MAX
//
// state  | meaning
// IDLE   | nothing accepted since reset, next in-range sample is not step-checked
// TRACK  | last accepted value below 3, hold or +1 is legal
// AT_MAX | last accepted value is 3, only 3 is legal

module count_sequence_checker #(
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       cnt_in,
    input  logic             cnt_valid,
    input  logic             err_clr,
    output logic             err_over,
`ifdef CHECK_STEP_EN
    output logic             err_step,
`endif
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       max_seen,
    output logic             at_max
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        AT_MAX = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       prev, prev_nxt;
    logic             over_smp;
    logic             in_smp;
    logic [1:0]       n;
    logic             step_viol;
    logic             violation;
    logic [ERR_W-1:0] count_nxt;

    assign n        = cnt_in[1:0];
    assign over_smp = cnt_valid &&  cnt_in[2];
    assign in_smp   = cnt_valid && !cnt_in[2];

`ifdef CHECK_STEP_EN
    always_comb begin
        step_viol = 1'b0;
        if (in_smp) begin
            case (state)
                TRACK:   step_viol = !((n == prev) || ({1'b0, n} == ({1'b0, prev} + 3'd1)));
                AT_MAX:  step_viol = (n != 2'd3);
                default: step_viol = 1'b0;
            endcase
        end
    end
`else
    assign step_viol = 1'b0;
`endif

    assign violation = over_smp || step_viol;

    // Every accepted in-range sample lands in prev, legal or not (a violation
    // resyncs), so the next state depends only on whether the sample is 3.
    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        if (in_smp) begin
            prev_nxt  = n;
            state_nxt = (n == 2'd3) ? AT_MAX : TRACK;
        end
    end

    // A violation in the same cycle as err_clr survives the clear.
    always_comb begin
        count_nxt = err_count;
        if (err_clr) begin
            count_nxt = violation ? {{(ERR_W-1){1'b0}}, 1'b1} : '0;
        end else if (violation && (err_count != {ERR_W{1'b1}})) begin
            count_nxt = err_count + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            prev  <= 2'd0;
        end else begin
            state <= state_nxt;
            prev  <= prev_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_over  <= 1'b0;
            err_count <= '0;
        end else begin
            err_over  <= err_clr ? over_smp : (err_over || over_smp);
            err_count <= count_nxt;
        end
    end

`ifdef CHECK_STEP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_step <= 1'b0;
        end else begin
            err_step <= err_clr ? step_viol : (err_step || step_viol);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_seen <= 3'd0;
        end else if (in_smp && ({1'b0, n} > max_seen)) begin
            max_seen <= {1'b0, n};
        end
    end

    // prev is always 3 while in AT_MAX; qualifying on it keeps the flag tied
    // to the value actually held rather than the state encoding alone.
    assign at_max = (state == AT_MAX) && (prev == 2'd3);

endmodule

// File: tb/tb_count_sequence_checker.sv
module tb_count_sequence_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] cnt_in = 3'd0;
    logic       cnt_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic       err_over;
    logic       err_step;
    logic [3:0] err_count;
    logic [2:0] max_seen;
    logic       at_max;

    int checks = 0;
    int errors = 0;

    count_sequence_checker #(.ERR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .cnt_valid (cnt_valid),
        .err_clr   (err_clr),
        .err_over  (err_over),
`ifdef CHECK_STEP_EN
        .err_step  (err_step),
`endif
        .err_count (err_count),
        .max_seen  (max_seen),
        .at_max    (at_max)
    );

`ifndef CHECK_STEP_EN
    assign err_step = 1'b0;
`endif

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then land 1 ns after the
    // next rising edge so outputs can be sampled.
    task automatic drive(input logic v, input logic [2:0] n, input logic clr);
        @(negedge clk);
        cnt_valid = v;
        cnt_in    = n;
        err_clr   = clr;
        @(posedge clk);
        #1;
        cnt_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({err_over, err_step, err_count, max_seen, at_max} !== 10'd0) begin
            $display("FAIL reset_outputs: got over=%b step=%b cnt=%0d max=%0d at_max=%b, expected all 0",
                     err_over, err_step, err_count, max_seen, at_max);
            errors++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ramp();
        logic [2:0] seq [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, seq[i], 1'b0);
            checks++;
            if (at_max !== (i >= 3)) begin
                $display("FAIL ramp_at_max[%0d]: got %b expected %b", i, at_max, (i >= 3));
                errors++;
            end
        end
        checks++;
        if (err_count !== 4'd0 || err_over !== 1'b0 || err_step !== 1'b0) begin
            $display("FAIL ramp_no_errors: got cnt=%0d over=%b step=%b expected 0/0/0", err_count, err_over, err_step);
            errors++;
        end
        checks++;
        if (max_seen !== 3'd3) begin
            $display("FAIL ramp_max_seen: got %0d expected 3", max_seen);
            errors++;
        end
    endtask

    task automatic test_over_range();
        do_reset();
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b1, 3'd6, 1'b0);
        checks++;
        if (err_over !== 1'b1 || err_count !== 4'd1 || max_seen !== 3'd1) begin
            $display("FAIL over_after_6: got over=%b cnt=%0d max=%0d expected 1/1/1", err_over, err_count, max_seen);
            errors++;
        end
        drive(1'b1, 3'd2, 1'b0);
        checks++;
        if (err_over !== 1'b1 || err_count !== 4'd1 || err_step !== 1'b0) begin
            $display("FAIL over_then_2: got over=%b cnt=%0d step=%b expected 1/1/0", err_over, err_count, err_step);
            errors++;
        end
        checks++;
        if (max_seen !== 3'd2) begin
            $display("FAIL over_max_seen: got %0d expected 2", max_seen);
            errors++;
        end
    endtask

    task automatic test_step();
`ifdef CHECK_STEP_EN
        logic       exp_step1 = 1'b1;
        logic [3:0] exp_cnt1  = 4'd1;
        logic [3:0] exp_cnt2  = 4'd2;
`else
        logic       exp_step1 = 1'b0;
        logic [3:0] exp_cnt1  = 4'd0;
        logic [3:0] exp_cnt2  = 4'd0;
`endif
        do_reset();
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b1, 3'd2, 1'b0);
        checks++;
        if (err_step !== exp_step1 || err_count !== exp_cnt1 || err_over !== 1'b0) begin
            $display("FAIL step_0_2: got step=%b cnt=%0d over=%b expected %b/%0d/0",
                     err_step, err_count, err_over, exp_step1, exp_cnt1);
            errors++;
        end
        drive(1'b1, 3'd3, 1'b0);
        checks++;
        if (at_max !== 1'b1 || err_count !== exp_cnt1) begin
            $display("FAIL step_2_3: got at_max=%b cnt=%0d expected 1/%0d", at_max, err_count, exp_cnt1);
            errors++;
        end
        drive(1'b1, 3'd1, 1'b0);
        checks++;
        if (err_count !== exp_cnt2 || at_max !== 1'b0) begin
            $display("FAIL step_3_1: got cnt=%0d at_max=%b expected %0d/0", err_count, at_max, exp_cnt2);
            errors++;
        end
        // After resync to 1, a 2 is legal and must not count.
        drive(1'b1, 3'd2, 1'b0);
        checks++;
        if (err_count !== exp_cnt2 || max_seen !== 3'd3) begin
            $display("FAIL step_resync: got cnt=%0d max=%0d expected %0d/3", err_count, max_seen, exp_cnt2);
            errors++;
        end
    endtask

    task automatic test_saturate_and_clear();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 3'd7, 1'b0);
        end
        checks++;
        if (err_count !== 4'd15 || err_over !== 1'b1) begin
            $display("FAIL sat_count: got cnt=%0d over=%b expected 15/1", err_count, err_over);
            errors++;
        end
        drive(1'b1, 3'd5, 1'b1);
        checks++;
        if (err_count !== 4'd1 || err_over !== 1'b1 || err_step !== 1'b0) begin
            $display("FAIL clr_with_violation: got cnt=%0d over=%b step=%b expected 1/1/0", err_count, err_over, err_step);
            errors++;
        end
        drive(1'b0, 3'd0, 1'b1);
        checks++;
        if (err_count !== 4'd0 || err_over !== 1'b0) begin
            $display("FAIL clr_plain: got cnt=%0d over=%b expected 0/0", err_count, err_over);
            errors++;
        end
        // FSM untouched by the clear: still IDLE, so 3 is accepted straight to AT_MAX.
        drive(1'b1, 3'd3, 1'b0);
        checks++;
        if (at_max !== 1'b1 || err_count !== 4'd0 || max_seen !== 3'd3) begin
            $display("FAIL clr_then_3: got at_max=%b cnt=%0d max=%0d expected 1/0/3", at_max, err_count, max_seen);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 3'd7, 1'b0);
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b1, 3'd2, 1'b0);
        drive(1'b1, 3'd3, 1'b0);
        checks++;
        if (at_max !== 1'b1 || err_count !== 4'd1) begin
            $display("FAIL pre_reset: got at_max=%b cnt=%0d expected 1/1", at_max, err_count);
            errors++;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({err_over, err_step, err_count, max_seen, at_max} !== 10'd0) begin
            $display("FAIL async_reset: got over=%b step=%b cnt=%0d max=%0d at_max=%b expected all 0",
                     err_over, err_step, err_count, max_seen, at_max);
            errors++;
        end
        #1;
        reset = 1'b0;
        drive(1'b1, 3'd2, 1'b0);
        checks++;
        if (err_count !== 4'd0 || err_step !== 1'b0 || max_seen !== 3'd2 || at_max !== 1'b0) begin
            $display("FAIL post_reset_2: got cnt=%0d step=%b max=%0d at_max=%b expected 0/0/2/0",
                     err_count, err_step, max_seen, at_max);
            errors++;
        end
    endtask

    task automatic test_invalid_hold();
        do_reset();
        drive(1'b1, 3'd0, 1'b0);
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b1, 3'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 3'd7, 1'b0);
            checks++;
            if (err_count !== 4'd1 || err_over !== 1'b1 || max_seen !== 3'd1 || at_max !== 1'b0 || err_step !== 1'b0) begin
                $display("FAIL invalid_hold[%0d]: got cnt=%0d over=%b max=%0d at_max=%b step=%b expected 1/1/1/0/0",
                         i, err_count, err_over, max_seen, at_max, err_step);
                errors++;
            end
        end
        // prev must still be 1 after the idle cycles: 2 is a legal step.
        drive(1'b1, 3'd2, 1'b0);
        checks++;
        if (err_count !== 4'd1 || max_seen !== 3'd2) begin
            $display("FAIL invalid_then_2: got cnt=%0d max=%0d expected 1/2", err_count, max_seen);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_over_range();
        test_step();
        test_saturate_and_clear();
        test_async_reset();
        test_invalid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
